// File: rtl/div_booth_companion.sv
// div_booth_companion: sequential signed divider with MIPS DIV semantics.
// Restoring shift-subtract on operand magnitudes, one quotient bit per clock,
// followed by a single sign-fixup cycle. The quotient goes to the Lo output
// and the remainder to the Hi output.
//
//   state | meaning
//   IDLE  | waiting for start; a zero divisor is reported here without leaving IDLE
//   RUN   | one restoring shift-subtract step per clock, WIDTH steps in total
//   FIX   | apply result signs, register outputs, pulse done
module div_booth_companion #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_total,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_A_in,
  input  logic [WIDTH-1:0] operand_B_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] rem_Hi_out,
  output logic [WIDTH-1:0] quot_Lo_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // Operand magnitudes and the trial subtraction for the current RUN step.
  // The most negative operand negates to itself, which reads correctly as
  // an unsigned magnitude. rem < dvsr always holds, so WIDTH+1 bits keep the
  // trial sign exact.
  always_comb begin
    a_mag  = operand_A_in[WIDTH-1] ? -operand_A_in : operand_A_in;
    b_mag  = operand_B_in[WIDTH-1] ? -operand_B_in : operand_B_in;
    rem_sh = {rem, quot[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr};
  end

  // Sequencing FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge reset_total) begin
    if (!reset_total) begin
      state       <= IDLE;
      rem         <= '0;
      quot        <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      rem_Hi_out  <= '0;
      quot_Lo_out <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (operand_B_in == '0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              quot   <= a_mag;
              dvsr   <= b_mag;
              rem    <= '0;
              sign_q <= operand_A_in[WIDTH-1] ^ operand_B_in[WIDTH-1];
              sign_r <= operand_A_in[WIDTH-1];
              cnt    <= CW'(WIDTH);
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            rem  <= trial[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= rem_sh[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quot_Lo_out <= sign_q ? -quot : quot;
          rem_Hi_out  <= sign_r ? -rem : rem;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_booth_companion.sv
// Directed, table-driven bench for div_booth_companion.
module tb_div_booth_companion;

  logic        clk;
  logic        reset_total;
  logic        start;
  logic [31:0] operand_A_in;
  logic [31:0] operand_B_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] rem_Hi_out;
  logic [31:0] quot_Lo_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  div_booth_companion #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset_total  (reset_total),
    .start        (start),
    .operand_A_in (operand_A_in),
    .operand_B_in (operand_B_in),
    .busy         (busy),
    .done         (done),
    .div_zero     (div_zero),
    .rem_Hi_out   (rem_Hi_out),
    .quot_Lo_out  (quot_Lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One division: start for a single edge, then wait (bounded) for done.
  task automatic run_vec(input vec_t v, input string tag);
    int  n;
    int  busy_low;
    bit  seen;
    @(negedge clk);
    operand_A_in = v.a;
    operand_B_in = v.b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    if (v.dz) begin
      chk({tag, " dz done"}, 32'(done), 32'd1);
      chk({tag, " dz flag"}, 32'(div_zero), 32'd1);
      chk({tag, " dz busy"}, 32'(busy), 32'd0);
      chk({tag, " dz quot hold"}, quot_Lo_out, v.q);
      chk({tag, " dz rem hold"}, rem_Hi_out, v.r);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " dz done width"}, 32'(done), 32'd0);
    end else begin
      chk({tag, " busy after start"}, 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      n        = 0;
      busy_low = 0;
      seen     = 1'b0;
      while (!seen && n < 40) begin
        @(posedge clk);
        #1;
        n++;
        if (done) seen = 1'b1;
        else if (busy !== 1'b1) busy_low++;
      end
      if (!seen) begin
        errors++;
        checks++;
        $display("FAIL %s timeout: no done within %0d cycles", tag, n);
      end else begin
        chk({tag, " latency"}, 32'(n), 32'd33);
        chk({tag, " busy gaps"}, 32'(busy_low), 32'd0);
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
        chk({tag, " div_zero"}, 32'(div_zero), 32'd0);
        chk({tag, " quot"}, quot_Lo_out, v.q);
        chk({tag, " rem"}, rem_Hi_out, v.r);
        @(posedge clk);
        #1;
        chk({tag, " done width"}, 32'(done), 32'd0);
      end
    end
  endtask

  initial begin
    int   dn;
    int   both;
    int   dtimes[$];
    vec_t v;

    vecs[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dz: 1'b0};
    vecs[1]  = '{a: 32'hFFFFFF9C,   b: 32'd7,          q: 32'hFFFFFFF2,   r: 32'hFFFFFFFE,   dz: 1'b0};
    vecs[2]  = '{a: 32'd100,        b: 32'hFFFFFFF9,   q: 32'hFFFFFFF2,   r: 32'd2,          dz: 1'b0};
    vecs[3]  = '{a: 32'hFFFFFF9C,   b: 32'hFFFFFFF9,   q: 32'd14,         r: 32'hFFFFFFFE,   dz: 1'b0};
    vecs[4]  = '{a: 32'd9,          b: 32'd4,          q: 32'd2,          r: 32'd1,          dz: 1'b0};
    vecs[5]  = '{a: 32'd5,          b: 32'd0,          q: 32'd2,          r: 32'd1,          dz: 1'b1};
    vecs[6]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   q: 32'h80000000,   r: 32'd0,          dz: 1'b0};
    vecs[7]  = '{a: 32'h80000000,   b: 32'd1,          q: 32'h80000000,   r: 32'd0,          dz: 1'b0};
    vecs[8]  = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          dz: 1'b0};
    vecs[9]  = '{a: 32'h7FFFFFFF,   b: 32'h80000000,   q: 32'd0,          r: 32'h7FFFFFFF,   dz: 1'b0};
    vecs[10] = '{a: 32'hFFFFFFF9,   b: 32'd2,          q: 32'hFFFFFFFD,   r: 32'hFFFFFFFF,   dz: 1'b0};
    vecs[11] = '{a: 32'hFFFFFFFF,   b: 32'd0,          q: 32'hFFFFFFFD,   r: 32'hFFFFFFFF,   dz: 1'b1};
    vecs[12] = '{a: 32'd1000,       b: 32'd7,          q: 32'd142,        r: 32'd6,          dz: 1'b0};

    reset_total  = 1'b0;
    start        = 1'b0;
    operand_A_in = '0;
    operand_B_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div_zero", 32'(div_zero), 32'd0);
    chk("reset quot", quot_Lo_out, 32'd0);
    chk("reset rem", rem_Hi_out, 32'd0);
    @(negedge clk);
    reset_total = 1'b1;

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort: restart attempt mid-run is ignored, then reset clears everything.
    @(negedge clk);
    operand_A_in = 32'd1000;
    operand_B_in = 32'd3;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
      if (i == 9) begin
        operand_A_in = 32'd55;
        operand_B_in = 32'd0;
        start        = 1'b1;
      end
      if (i == 10) start = 1'b0;
      if (i == 15) chk("abort busy mid-run", 32'(busy), 32'd1);
    end
    chk("abort no early done", 32'(dn), 32'd0);
    reset_total = 1'b0;
    #1;
    chk("abort quot cleared", quot_Lo_out, 32'd0);
    chk("abort rem cleared", rem_Hi_out, 32'd0);
    chk("abort busy cleared", 32'(busy), 32'd0);
    chk("abort done low", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_total = 1'b1;
    dn   = 0;
    both = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
      if (busy) both++;
    end
    chk("abort no done after reset", 32'(dn), 32'd0);
    chk("abort stays idle", 32'(both), 32'd0);
    v = '{a: 32'd1000, b: 32'd3, q: 32'd333, r: 32'd1, dz: 1'b0};
    run_vec(v, "after abort");

    // Back-to-back with start held high.
    @(negedge clk);
    operand_A_in = 32'd7;
    operand_B_in = 32'd7;
    start        = 1'b1;
    @(posedge clk);
    both = 0;
    for (int n = 1; n <= 105; n++) begin
      @(posedge clk);
      #1;
      if (done && busy) both++;
      if (done) begin
        dtimes.push_back(n);
        chk($sformatf("b2b quot @%0d", n), quot_Lo_out, 32'd1);
        chk($sformatf("b2b rem @%0d", n), rem_Hi_out, 32'd0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b done&busy overlap", 32'(both), 32'd0);
    chk("b2b done count", 32'(dtimes.size()), 32'd3);
    if (dtimes.size() == 3) begin
      chk("b2b done #1 time", 32'(dtimes[0]), 32'd33);
      chk("b2b done #2 time", 32'(dtimes[1]), 32'd67);
      chk("b2b done #3 time", 32'(dtimes[2]), 32'd101);
    end
    repeat (40) @(posedge clk);
    #1;
    chk("b2b drained busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
